dtc_vote_window: RTL and testbench



---
 rtl/dtc_vote_window.sv | 110 +++++++++++
 tb/tb_dtc_vote_window.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dtc_vote_window.sv
// Windowed majority vote over WINDOW class decisions, one result per window via valid/ready.
// Optional DTC_VOTE_ABSTAIN_EN: class 0 means "no decision" and never collects votes.
module dtc_vote_window #(
  parameter int WINDOW = 16,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_class,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_class,
  output logic [CW-1:0] out_votes,
  output logic          out_tie
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, EMIT} state_t;

  localparam logic [CW-1:0] WIN = CW'(WINDOW);

`ifdef DTC_VOTE_ABSTAIN_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  state_t        state;
  logic [CW-1:0] cnt [8];
  logic [CW-1:0] smp;
  logic [CW-1:0] smp_inc;
  logic          count_sample;
  logic [2:0]    best_class;
  logic [CW-1:0] best_votes;
  logic          best_tie;

  assign smp_inc = smp + 1'b1;

`ifdef DTC_VOTE_ABSTAIN_EN
  assign count_sample = (in_class != 3'd0);
`else
  assign count_sample = 1'b1;
`endif

  // Strict '>' keeps the lowest index on ties; an all-abstain window stays at class 0 / 0 votes.
  always_comb begin
    best_class = 3'd0;
    best_votes = '0;
    best_tie   = 1'b0;
    for (int i = FIRST; i < 8; i++) begin
      if (cnt[i] > best_votes) begin
        best_votes = cnt[i];
        best_class = 3'(i);
      end
    end
    for (int i = FIRST; i < 8; i++) begin
      if ((3'(i) != best_class) && (cnt[i] == best_votes) && (best_votes != '0))
        best_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      smp       <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_class <= 3'd0;
      out_votes <= '0;
      out_tie   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // in_ready is high throughout ACCUM, so in_valid alone marks an accept
          if (in_valid) begin
            smp <= smp_inc;
            if (count_sample) cnt[in_class] <= cnt[in_class] + 1'b1;
            if (smp_inc == WIN) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_class <= best_class;
          out_votes <= best_votes;
          out_tie   <= best_tie;
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            smp       <= '0;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            state     <= ACCUM;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_vote_window.sv
// Directed bench for dtc_vote_window at WINDOW = 4, 1 and 255 with an expected-result queue.
// Expectations follow DTC_VOTE_ABSTAIN_EN when it is defined for the build.
module tb_dtc_vote_window;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] in_valid, in_ready, out_valid, out_ready, out_tie;
  logic [2:0] in_class  [3];
  logic [2:0] out_class [3];
  logic [7:0] out_votes [3];
  logic [2:0] votes4;
  logic [0:0] votes1;
  logic [7:0] votes255;

  assign out_votes[0] = {5'd0, votes4};
  assign out_votes[1] = {7'd0, votes1};
  assign out_votes[2] = votes255;

  dtc_vote_window #(.WINDOW(4)) u_w4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_class(in_class[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_class(out_class[0]), .out_votes(votes4), .out_tie(out_tie[0])
  );

  dtc_vote_window #(.WINDOW(1)) u_w1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_class(in_class[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_class(out_class[1]), .out_votes(votes1), .out_tie(out_tie[1])
  );

  dtc_vote_window #(.WINDOW(255)) u_w255 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_class(in_class[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_class(out_class[2]), .out_votes(votes255), .out_tie(out_tie[2])
  );

  typedef struct {
    logic [2:0] cls;
    logic [7:0] votes;
    logic       tie;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef DTC_VOTE_ABSTAIN_EN
  localparam bit ABSTAIN = 1'b1;
`else
  localparam bit ABSTAIN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and return just after the edge that accepts it.
  task automatic send(input int s, input logic [2:0] c);
    bit done = 1'b0;
    in_valid[s] = 1'b1;
    in_class[s] = c;
    for (int k = 0; k < 50 && !done; k++) begin
      if (in_ready[s] === 1'b1) done = 1'b1;
      tick();
    end
    if (!done) chk("send_timeout", 32'(done), 1);
  endtask

  // Stream n samples back to back (pattern a,b,c,d repeating) and queue the expected result.
  task automatic window(input int s, input int n,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d,
                        input logic [2:0] ecls, input logic [7:0] evotes, input logic etie);
    logic [2:0] pat [4];
    exp_t e;
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
    e.cls = ecls; e.votes = evotes; e.tie = etie;
    sb.push_back(e);
    for (int i = 0; i < n; i++) send(s, pat[i % 4]);
    in_valid[s] = 1'b0;
    chk("resolve_in_ready", 32'(in_ready[s]), 0);
    chk("resolve_out_valid", 32'(out_valid[s]), 0);
    tick();
    chk("latency2_out_valid", 32'(out_valid[s]), 1);
  endtask

  // Pop the expected result, compare, complete the handshake and check the return to ACCUM.
  task automatic collect(input int s);
    exp_t e;
    bit   seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (out_valid[s] === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("out_valid_timeout", 32'(seen), 1);
    e = sb.pop_front();
    chk("out_class", 32'(out_class[s]), 32'(e.cls));
    chk("out_votes", 32'(out_votes[s]), 32'(e.votes));
    chk("out_tie", 32'(out_tie[s]), 32'(e.tie));
    $display("window[%0d] class=%0d votes=%0d tie=%0d", s, out_class[s], out_votes[s], out_tie[s]);
    out_ready[s] = 1'b1;
    tick();
    out_ready[s] = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid[s]), 0);
    chk("post_hs_in_ready", 32'(in_ready[s]), 1);
  endtask

  initial begin
    exp_t dropped;
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) in_class[i] = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", 32'(in_ready[i]), 1);
      chk("reset_out_valid", 32'(out_valid[i]), 0);
      chk("reset_out_class", 32'(out_class[i]), 0);
      chk("reset_out_votes", 32'(out_votes[i]), 0);
      chk("reset_out_tie", 32'(out_tie[i]), 0);
    end

    // Reset mid-window: the two class-5 votes must be discarded.
    send(0, 3'd5);
    send(0, 3'd5);
    in_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready[0]), 1);
    chk("midrst_out_valid", 32'(out_valid[0]), 0);
    tick();
    rst = 1'b0;
    tick();
    window(0, 4, 3'd5, 3'd5, 3'd2, 3'd2, 3'd2, 8'd2, 1'b1);
    collect(0);

    // Clear majority and tie-to-lowest.
    window(0, 4, 3'd3, 3'd3, 3'd6, 3'd3, 3'd3, 8'd3, 1'b0);
    collect(0);
    window(0, 4, 3'd7, 3'd2, 3'd7, 3'd2, 3'd2, 8'd2, 1'b1);
    collect(0);

    // Output backpressure with in_valid asserted: nothing absorbed, outputs stable.
    window(0, 4, 3'd1, 3'd1, 3'd1, 3'd4, 3'd1, 8'd3, 1'b0);
    in_valid[0] = 1'b1;
    in_class[0] = 3'd6;
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_ready", 32'(in_ready[0]), 0);
      chk("bp_out_valid", 32'(out_valid[0]), 1);
      chk("bp_out_class", 32'(out_class[0]), 1);
      chk("bp_out_votes", 32'(out_votes[0]), 3);
      tick();
    end
    in_valid[0] = 1'b0;
    collect(0);
    window(0, 4, 3'd4, 3'd4, 3'd6, 3'd6, 3'd4, 8'd2, 1'b1);
    collect(0);

    // Abstain handling of class 0.
    if (ABSTAIN) window(0, 4, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 8'd1, 1'b0);
    else         window(0, 4, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 8'd3, 1'b0);
    collect(0);
    if (ABSTAIN) window(0, 4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
    else         window(0, 4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd4, 1'b0);
    collect(0);

    // Reset while in EMIT clears the held result.
    window(0, 4, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 8'd4, 1'b0);
    dropped = sb.pop_front();
    chk("emit_out_votes", 32'(out_votes[0]), 32'(dropped.votes));
    rst = 1'b1;
    #1;
    chk("emitrst_out_valid", 32'(out_valid[0]), 0);
    chk("emitrst_out_class", 32'(out_class[0]), 0);
    chk("emitrst_out_votes", 32'(out_votes[0]), 0);
    chk("emitrst_out_tie", 32'(out_tie[0]), 0);
    chk("emitrst_in_ready", 32'(in_ready[0]), 1);
    tick();
    rst = 1'b0;
    tick();

    // WINDOW = 1: every sample is its own window.
    window(1, 1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 8'd1, 1'b0);
    collect(1);
    if (ABSTAIN) window(1, 1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
    else         window(1, 1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd1, 1'b0);
    collect(1);
    window(1, 1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 8'd1, 1'b0);
    collect(1);

    // WINDOW = 255: full-scale count and a near-even split (64,64,64,63).
    window(2, 255, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 8'd255, 1'b0);
    collect(2);
    window(2, 255, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 8'd64, 1'b1);
    collect(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
